// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative unsigned shift-add multiplier / restoring divider driving the ALU B-mux controls.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero,
  output logic             alu_f2,
  output logic             alu_en
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opreg_q, opreg_d;
  logic dz_q, dz_d;
  logic [WIDTH:0] sum, rem, diff;
  logic ge, last;
  // rem keeps hi's shifted-out MSB so the compare sees the full WIDTH+1-bit partial remainder
  always_comb begin
    sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opreg_q} : '0);
    rem = {hi_q, lo_q[WIDTH-1]};
    diff = rem - {1'b0, opreg_q};
    ge = rem >= {1'b0, opreg_q};
    last = cnt_q == CW'(WIDTH - 1);
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    opreg_d = opreg_q;
    dz_d = dz_q;
    unique case (state_q)
      IDLE: if (start) begin
        cnt_d = '0;
        dz_d = op && (b == '0);
        if (!op) begin
          state_d = MUL;
          hi_d = '0;
          lo_d = b;
          opreg_d = a;
        end else if (b == '0) begin
          state_d = DONE;
          hi_d = a;
          lo_d = '1;
        end else begin
          state_d = DIV;
          hi_d = '0;
          lo_d = a;
          opreg_d = b;
        end
      end
      MUL: begin
        hi_d = sum[WIDTH:1];
        lo_d = {sum[0], lo_q[WIDTH-1:1]};
        cnt_d = last ? '0 : cnt_q + CW'(1);
        state_d = last ? DONE : MUL;
      end
      DIV: begin
        hi_d = ge ? diff[WIDTH-1:0] : rem[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], ge};
        cnt_d = last ? '0 : cnt_q + CW'(1);
        state_d = last ? DONE : DIV;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      opreg_q <= '0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      opreg_q <= opreg_d;
      dz_q <= dz_d;
    end
  end
  assign busy = (state_q == MUL) || (state_q == DIV);
  assign done = state_q == DONE;
  assign hi = hi_q;
  assign lo = lo_q;
  assign div_zero = dz_q;
  assign alu_f2 = state_q == DIV;
  assign alu_en = ((state_q == MUL) && lo_q[0]) || (state_q == DIV);
endmodule
